// File: rtl/cpu_pkg.sv
// Shared decode constants, FSM encoding and the single-cycle ALU evaluator
// for the execute stage.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    // Returns {supported, value} for every single-cycle funct; multu and
    // unknown functs report unsupported so the caller can zero the result.
    function automatic logic [XLEN:0] alu_eval(input logic [5:0]      funct,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
        logic [XLEN-1:0] v;
        logic            ok;
        v  = '0;
        ok = 1'b1;
        case (funct)
            F_ADD, F_ADDU: v = a + b;
            F_SUB, F_SUBU: v = a - b;
            F_AND:         v = a & b;
            F_OR:          v = a | b;
            F_XOR:         v = a ^ b;
            F_NOR:         v = ~(a | b);
            F_SLT:         v = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU:        v = {{(XLEN-1){1'b0}}, (a < b)};
            F_MFHI:        v = hi;
            F_MFLO:        v = lo;
            default:       ok = 1'b0;
        endcase
        return {ok, v};
    endfunction

endpackage

// File: rtl/exec_stage_if.sv
// Operand/result handshake bundle between register read, the execute stage
// and writeback.
interface exec_stage_if #(parameter int W = 32);

    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instru;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   dest;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    // Environment side: supplies operands and consumes results.
    modport master (
        output in_valid, instru, data_a, data_b, out_ready,
        input  in_ready, out_valid, result, dest, hi, lo
    );

    // Execute stage side.
    modport slave (
        input  in_valid, instru, data_a, data_b, out_ready,
        output in_ready, out_valid, result, dest, hi, lo
    );

endinterface

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// done_o is high during the final step; prod_o carries the full product in
// that same cycle so the caller can capture it on the final step edge.
module mul_iter
    import cpu_pkg::*;
#(
    parameter int W     = 32,
    parameter int STEPS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);

    localparam int CW = $clog2(STEPS);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   acc_step;

    // Next-state: load on start, otherwise add the current partial product
    // and shift both operands while busy.
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS-1))
                busy_d = 1'b0;
        end
    end

    assign done_o = busy_q && (cnt_q == CW'(STEPS-1));
    assign prod_o = acc_step;

    // Engine state; reset abandons any multiply in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU / mfhi / mflo plus a multi-cycle multu
// that blocks new operands until hi/lo are written.
module exec_stage
    import cpu_pkg::*;
#(
    parameter int W         = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    exec_stage_if.slave bus
);

    state_e          state_q;
    logic            out_valid_q;
    logic [W-1:0]    result_q;
    logic [4:0]      dest_q;
    logic [W-1:0]    hi_q, lo_q;

    instr_t          ins;
    logic            accept;
    logic            is_special;
    logic            is_multu;
    logic            op_ok;
    logic [W:0]      ev;
    logic            mul_start;
    logic            mul_done;
    logic [2*W-1:0]  mul_prod;
    logic            unused_fields;

    assign ins           = instr_t'(bus.instru);
    assign unused_fields = ^{ins.rs, ins.rt, ins.shamt};

    assign bus.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    assign is_special    = (ins.opcode == OP_SPECIAL);
    assign is_multu      = is_special && (ins.funct == F_MULTU);
    assign ev            = alu_eval(ins.funct, bus.data_a, bus.data_b, hi_q, lo_q);
    assign op_ok         = is_special && ev[W];
    assign mul_start     = accept && is_multu;

    mul_iter #(.W(W), .STEPS(MUL_STEPS)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(mul_start),
        .a_i    (bus.data_a),
        .b_i    (bus.data_b),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    // Control FSM with registered result/dest/hi/lo; a drain and a new
    // completion on the same edge leave out_valid set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dest_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            if (bus.out_ready)
                out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_multu) begin
                            state_q <= ST_MUL;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= op_ok ? ev[W-1:0] : '0;
                            dest_q      <= op_ok ? ins.rd : 5'd0;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        hi_q        <= mul_prod[2*W-1:W];
                        lo_q        <= mul_prod[W-1:0];
                        out_valid_q <= 1'b1;
                        result_q    <= '0;
                        dest_q      <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.dest      = dest_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule
